// File: rtl/scan_pkg.sv
// Shared definitions for the scan-side request initiator: op codes,
// command frame field positions, FSM state type and request bundle.
package scan_pkg;
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;

    // frame = {op[1:0], addr[15:0], data[15:0]}
    localparam int OP_HI   = 33;
    localparam int OP_LO   = 32;
    localparam int ADDR_HI = 31;
    localparam int ADDR_LO = 16;
    localparam int DATA_HI = 15;
    localparam int DATA_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic              ren;
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;
endpackage

// File: rtl/scan_rwctr_if.sv
// Request bus between the scan initiator (master) and the SRAM/register router.
interface scan_rwctr_if;
    import scan_pkg::*;

    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output ren, wen, addr, wdata, input rdata, ready);
    modport slave  (input ren, wen, addr, wdata, output rdata, ready);
endinterface

// File: rtl/scan_shift_reg.sv
// Command frame register: shifts left (LSB in, MSB out) and can overwrite
// the data field in parallel with captured read data.
module scan_shift_reg
    import scan_pkg::*;
#(
    parameter int FRAME_W = 34
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               shift_in,
    input  logic               load_lo,
    input  logic [DATA_W-1:0]  load_data,
    output logic [FRAME_W-1:0] sr
);
    always_ff @(posedge clk) begin
        if (rst)
            sr <= '0;
        else if (load_lo)
            sr[DATA_HI:DATA_LO] <= load_data;
        else if (shift_en)
            sr <= {sr[FRAME_W-2:0], shift_in};
    end
endmodule

// File: rtl/scan_rwctr.sv
// Scan-side initiator: decodes the shifted-in frame on an update strobe,
// issues one read/write, waits for ready (with timeout) and folds read data back.
module scan_rwctr
    import scan_pkg::*;
#(
    parameter int FRAME_W        = 34,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scan_in,
    input  logic          scan_en,
    input  logic          scan_update,
    output logic          scan_out,
    output logic          busy,
    output logic          done,
    output logic          err,
    scan_rwctr_if.master  bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    req_t               req;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] sr;
    logic [1:0]         op;
    logic               shift_en;
    logic               load_lo;
    logic [DATA_W-1:0]  load_data;

    assign op       = sr[OP_HI:OP_LO];
    assign scan_out = sr[FRAME_W-1];
    // an update on the same edge as scan_en launches from the unshifted frame
    assign shift_en = (state == ST_IDLE) && scan_en && !scan_update;

    // read completion captures rdata; a read timeout zeroes the data field
    always_comb begin
        load_lo   = 1'b0;
        load_data = bus.rdata;
        if (state == ST_REQ && req.ren) begin
            if (bus.ready) begin
                load_lo = 1'b1;
            end else if (cnt == TMO_LAST) begin
                load_lo   = 1'b1;
                load_data = '0;
            end
        end
    end

    scan_shift_reg #(.FRAME_W(FRAME_W)) u_sr (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .shift_in  (scan_in),
        .load_lo   (load_lo),
        .load_data (load_data),
        .sr        (sr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            req   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (scan_update) begin
                        if (op == OP_READ || op == OP_WRITE) begin
                            req.ren   <= (op == OP_READ);
                            req.wen   <= (op == OP_WRITE);
                            req.addr  <= sr[ADDR_HI:ADDR_LO];
                            req.wdata <= sr[DATA_HI:DATA_LO];
                            cnt       <= '0;
                            busy      <= 1'b1;
                            err       <= 1'b0;
                            state     <= ST_REQ;
                        end else begin
                            if (op == OP_RSVD)
                                err <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end
                    end
                end
                ST_REQ: begin
                    // overrun: flag it but let the current transaction finish
                    if (scan_update)
                        err <= 1'b1;
                    if (bus.ready) begin
                        req.ren <= 1'b0;
                        req.wen <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_FIN;
                    end else if (cnt == TMO_LAST) begin
                        req.ren <= 1'b0;
                        req.wen <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        state   <= ST_FIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    if (scan_update)
                        err <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ren   = req.ren;
    assign bus.wen   = req.wen;
    assign bus.addr  = req.addr;
    assign bus.wdata = req.wdata;
endmodule

// File: tb/tb_scan_rwctr.sv
// Directed bench for scan_rwctr: transaction-level reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_scan_rwctr;
    import scan_pkg::*;

    localparam int FW  = 34;
    localparam int TMO = 255;

    logic clk = 1'b0;
    logic rst, scan_in, scan_en, scan_update;
    logic scan_out, busy, done, err;

    scan_rwctr_if bus();

    scan_rwctr #(.FRAME_W(FW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_in     (scan_in),
        .scan_en     (scan_en),
        .scan_update (scan_update),
        .scan_out    (scan_out),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = request outstanding, 2 = finishing
    logic [33:0] m_frame;
    int          m_phase;
    bit          m_rd;
    int          m_waited;
    logic        m_err;
    logic [15:0] m_addr, m_wdata;

    always @(posedge clk) begin
        if (rst) begin
            m_frame <= '0; m_phase <= 0; m_rd <= 1'b0; m_waited <= 0;
            m_err <= 1'b0; m_addr <= '0; m_wdata <= '0;
        end else begin
            case (m_phase)
                0: begin
                    if (scan_update) begin
                        if (m_frame[33:32] == 2'b01 || m_frame[33:32] == 2'b10) begin
                            m_addr   <= m_frame[31:16];
                            m_wdata  <= m_frame[15:0];
                            m_rd     <= (m_frame[33:32] == 2'b01);
                            m_err    <= 1'b0;
                            m_waited <= 0;
                            m_phase  <= 1;
                        end else begin
                            if (m_frame[33:32] == 2'b11) m_err <= 1'b1;
                            m_phase <= 2;
                        end
                    end else if (scan_en) begin
                        m_frame <= {m_frame[32:0], scan_in};
                    end
                end
                1: begin
                    if (scan_update) m_err <= 1'b1;
                    if (bus.ready) begin
                        if (m_rd) m_frame[15:0] <= bus.rdata;
                        m_phase <= 2;
                    end else if (m_waited + 1 >= TMO) begin
                        m_err <= 1'b1;
                        if (m_rd) m_frame[15:0] <= 16'h0000;
                        m_phase <= 2;
                    end else begin
                        m_waited <= m_waited + 1;
                    end
                end
                default: begin
                    if (scan_update) m_err <= 1'b1;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("scan_out", 34'(scan_out), 34'(m_frame[33]));
            check("busy",     34'(busy),     34'(m_phase == 1));
            check("done",     34'(done),     34'(m_phase == 2));
            check("err",      34'(err),      34'(m_err));
            check("ren",      34'(bus.ren),  34'(m_phase == 1 && m_rd));
            check("wen",      34'(bus.wen),  34'(m_phase == 1 && !m_rd));
            check("addr",     34'(bus.addr), 34'(m_addr));
            check("wdata",    34'(bus.wdata),34'(m_wdata));
        end
    end

    // shifts f in MSB-first; old collects what scan_out presented meanwhile
    task automatic shift_frame(input logic [33:0] f, output logic [33:0] old);
        for (int i = 33; i >= 0; i--) begin
            old[i]  = scan_out;
            scan_in = f[i];
            scan_en = 1'b1;
            @(negedge clk);
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic pulse_update;
        scan_update = 1'b1;
        @(negedge clk);
        scan_update = 1'b0;
    endtask

    // hold ready low for n-1 cycles then high for one; count request cycles seen
    task automatic finish_req(input int n, output int req_cyc);
        req_cyc = 0;
        for (int k = 0; k < n; k++) begin
            if (bus.ren || bus.wen) req_cyc++;
            if (k == n - 1) bus.ready = 1'b1;
            @(negedge clk);
        end
        bus.ready = 1'b0;
    endtask

    logic [33:0] old;
    int          cyc;

    initial begin
        rst = 1'b1; scan_in = 1'b0; scan_en = 1'b0; scan_update = 1'b0;
        bus.ready = 1'b0; bus.rdata = 16'h0000;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;
        check("reset_outs", 34'({busy, done, err, bus.ren, bus.wen, scan_out}), 34'(6'b0));
        check("reset_bus", 34'({bus.addr, bus.wdata}), 34'(0));

        // write, ready on second request cycle
        shift_frame({2'b10, 16'h0123, 16'hBEEF}, old);
        check("reset_sr", old, 34'h0);
        pulse_update;
        check("wr_req", 34'({bus.wen, bus.ren, busy}), 34'(3'b101));
        check("wr_addr", 34'(bus.addr), 34'(16'h0123));
        check("wr_wdata", 34'(bus.wdata), 34'(16'hBEEF));
        finish_req(2, cyc);
        check("wr_cycles", 34'(cyc), 34'(2));
        check("wr_done", 34'({done, bus.wen, busy, err}), 34'(4'b1000));
        @(negedge clk);
        check("wr_done_once", 34'(done), 34'(0));

        // read, ready on third request cycle
        shift_frame({2'b01, 16'h8000, 16'h0000}, old);
        check("wr_sr_kept", old, {2'b10, 16'h0123, 16'hBEEF});
        pulse_update;
        check("rd_req", 34'({bus.ren, bus.wen, bus.addr}), 34'({2'b10, 16'h8000}));
        bus.rdata = 16'hA5A5;
        finish_req(3, cyc);
        check("rd_cycles", 34'(cyc), 34'(3));
        check("rd_done", 34'({done, bus.ren, err}), 34'(3'b100));
        @(negedge clk);

        // reserved op while reading back the read frame
        shift_frame({2'b11, 16'h0000, 16'h0000}, old);
        check("rd_shiftout", old, {2'b01, 16'h8000, 16'hA5A5});
        pulse_update;
        check("rsvd", 34'({bus.ren, bus.wen, busy, done, err}), 34'(5'b00011));
        @(negedge clk);
        check("rsvd_done_once", 34'({done, err}), 34'(2'b01));

        // write with overrun update during REQ
        shift_frame({2'b10, 16'h4444, 16'h5555}, old);
        pulse_update;
        check("ovr_err_clr", 34'({bus.wen, err}), 34'(2'b10));
        pulse_update;
        check("ovr_err_set", 34'({bus.wen, err}), 34'(2'b11));
        finish_req(1, cyc);
        check("ovr_done", 34'({done, err, bus.wen}), 34'(3'b110));
        @(negedge clk);

        // read timeout
        shift_frame({2'b01, 16'h0010, 16'h1234}, old);
        pulse_update;
        check("tmo_req", 34'({bus.ren, err}), 34'(2'b10));
        cyc = 0;
        while (bus.ren && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        check("tmo_cycles", 34'(cyc), 34'(TMO));
        check("tmo_done", 34'({done, err, bus.ren}), 34'(3'b110));
        @(negedge clk);

        // simultaneous shift and update: launch from unshifted frame
        shift_frame({2'b10, 16'h0AAA, 16'h0555}, old);
        check("tmo_sr", old, {2'b01, 16'h0010, 16'h0000});
        scan_en = 1'b1; scan_in = 1'b1; scan_update = 1'b1;
        @(negedge clk);
        scan_en = 1'b0; scan_in = 1'b0; scan_update = 1'b0;
        check("sim_req", 34'({bus.wen, bus.addr, bus.wdata}), 34'({1'b1, 16'h0AAA, 16'h0555}));
        finish_req(1, cyc);
        @(negedge clk);
        shift_frame({2'b01, 16'h8001, 16'h0000}, old);
        check("sim_noshift", old, {2'b10, 16'h0AAA, 16'h0555});

        // reset in the middle of a read
        pulse_update;
        check("rstreq_ren", 34'(bus.ren), 34'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstreq_outs", 34'({bus.ren, busy, done, err, scan_out}), 34'(5'b0));
        cyc = 0;
        repeat (5) begin
            if (done) cyc++;
            @(negedge clk);
        end
        check("rstreq_nodone", 34'(cyc), 34'(0));
        shift_frame(34'h0, old);
        check("rstreq_sr", old, 34'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
